// File: rtl/bcd2bin_if.sv
// bcd2bin_if: en/done handshake bundle for the BCD-to-binary converter.
// master drives en/digs; slave returns dout/busy/done/err.
interface bcd2bin_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DIGS   = 3
);
  logic                    en;
  logic [4*NUM_DIGS-1:0]   digs;
  logic [DATA_WIDTH-1:0]   dout;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output en,
    output digs,
    input  dout,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  en,
    input  digs,
    output dout,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/bcd2bin.sv
// bcd2bin: sequential BCD-to-binary converter, one digit per clock, MSD first.
// Ports: clk, rst (async active-low), bus (slave: en,digs -> dout,busy,done,err). Macro BCD2BIN_CHECK_EN enables err.
module bcd2bin #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DIGS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  bcd2bin_if.slave   bus
);

  localparam int IW = (NUM_DIGS > 1) ? $clog2(NUM_DIGS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FINISH
  } state_t;

  state_t                  state;
  logic [4*NUM_DIGS-1:0]   digs_q;
  logic [DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]   acc_nxt;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic [IW-1:0]           idx;
  logic                    busy_q;
  logic                    done_q;
  logic [3:0]              dig_a [NUM_DIGS];
  logic [3:0]              digit;

  for (genvar g = 0; g < NUM_DIGS; g++) begin : g_dig
    assign dig_a[g] = digs_q[4*g +: 4];
  end

  assign digit = dig_a[idx];

`ifdef BCD2BIN_CHECK_EN
  logic [DATA_WIDTH+3:0]   sum;
  logic                    ovf;
  logic                    bad;
  logic                    err_q;

  // Four spare bits: acc*10+15 always fits, so any
  // nonzero top nibble means the value left the range.
  assign sum = {4'b0, acc} * (DATA_WIDTH+4)'(10)
             + (DATA_WIDTH+4)'(digit);
  assign acc_nxt = sum[DATA_WIDTH-1:0];
  assign bus.err = err_q;
`else
  assign acc_nxt = acc * DATA_WIDTH'(10)
                 + DATA_WIDTH'(digit);
  assign bus.err = 1'b0;
`endif

  assign bus.dout = dout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      digs_q <= '0;
      acc    <= '0;
      idx    <= '0;
      dout_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
      ovf    <= 1'b0;
      bad    <= 1'b0;
      err_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.en) begin
            digs_q <= bus.digs;
            acc    <= '0;
            idx    <= IW'(NUM_DIGS-1);
            busy_q <= 1'b1;
            state  <= CONVERT;
`ifdef BCD2BIN_CHECK_EN
            ovf    <= 1'b0;
            bad    <= 1'b0;
`endif
          end
        end
        CONVERT: begin
          acc <= acc_nxt;
`ifdef BCD2BIN_CHECK_EN
          if (sum[DATA_WIDTH+3:DATA_WIDTH] != 4'd0)
            ovf <= 1'b1;
          if (digit > 4'd9)
            bad <= 1'b1;
`endif
          if (idx == '0)
            state <= FINISH;
          else
            idx <= idx - IW'(1);
        end
        FINISH: begin
          dout_q <= acc;
`ifdef BCD2BIN_CHECK_EN
          err_q  <= ovf | bad;
`endif
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
